// File: rtl/face_result_serializer.sv
// -----------------------------------------------------------------------------
// face_result_serializer
//
// Collects the bounding boxes reported by the face detector during one frame
// and, when the frame is finished, sends them to the UART transmitter as one
// counted byte packet.
//
// Packet layout:
//   header = {overflow, count[6:0]}
//   then, for each stored face in arrival order: x1, y1, x2, y2.
//   Each coordinate is COORD_W/8 bytes, most significant byte first.
//
// Parameters:
//   MAX_FACES  buffer depth in faces (1..127)
//   COORD_W    coordinate width, 8 or 16
//
// Ports:
//   clock       system clock
//   reset       synchronous active-high reset
//   face_vld    one-cycle pulse: face_x1/y1/x2/y2 are valid
//   face_x1..   box left/top/right/bottom
//   frame_done  one-cycle pulse: detector has finished the current frame
//   tx_data     byte presented to the transmitter
//   tx_send     level request to the transmitter, held until tx_done
//   tx_done     one-cycle pulse from the transmitter: byte has been sent
//   busy        high while a packet is being streamed
//   overflow    sticky: faces were lost for the current frame
// -----------------------------------------------------------------------------
module face_result_serializer #(
    parameter int MAX_FACES = 30,
    parameter int COORD_W   = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               face_vld,
    input  logic [COORD_W-1:0] face_x1,
    input  logic [COORD_W-1:0] face_y1,
    input  logic [COORD_W-1:0] face_x2,
    input  logic [COORD_W-1:0] face_y2,
    input  logic               frame_done,
    output logic [7:0]         tx_data,
    output logic               tx_send,
    input  logic               tx_done,
    output logic               busy,
    output logic               overflow
);

    localparam int BPC        = COORD_W / 8;          // bytes per coordinate
    localparam int BPF        = 4 * BPC;              // bytes per face
    localparam int FACE_W     = 4 * COORD_W;
    localparam int IDX_W      = (MAX_FACES > 1) ? $clog2(MAX_FACES) : 1;
    localparam int BYTE_IDX_W = $clog2(BPF);

    localparam logic [6:0]            MAX_CNT   = 7'(MAX_FACES);
    localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BPF - 1);

    typedef enum logic [1:0] {
        IDLE,
        HDR_LOAD,
        SEND,
        LOAD
    } state_t;

    state_t                  state;
    logic [6:0]              count;      // faces stored for the current frame
    logic [6:0]              pkt_count;  // count frozen at the start of a packet
    logic                    lost;       // a face arrived while streaming
    logic                    last_byte;  // byte currently in tx_data ends the packet
    logic [IDX_W-1:0]        face_idx;
    logic [BYTE_IDX_W-1:0]   byte_idx;

    logic [FACE_W-1:0]       buffer [MAX_FACES];

    logic                    store;
    logic [FACE_W-1:0]       cur_face;
    logic [BYTE_IDX_W-1:0]   rev_idx;
    logic [7:0]              cur_byte;
    logic [IDX_W-1:0]        last_face;
    logic                    on_last_face;

    // Faces are only accepted while idle and while there is room.
    assign store = (state == IDLE) && face_vld && (count < MAX_CNT);

    // NOTE: the face buffer has no reset; occupancy is tracked by count, so
    // stale entries are never read and resetting the array would only cost
    // logic.
    always_ff @(posedge clock) begin
        if (store) begin
            buffer[count[IDX_W-1:0]] <= {face_x1, face_y1, face_x2, face_y2};
        end
    end

    // Faces are stored as {x1, y1, x2, y2}, so byte 0 of a face is the MSB of
    // the word; reversing the index turns the byte number into a bit offset.
    assign cur_face     = buffer[face_idx];
    assign rev_idx      = LAST_BYTE - byte_idx;
    assign cur_byte     = cur_face[{rev_idx, 3'b000} +: 8];
    assign last_face    = IDX_W'(pkt_count - 7'd1);
    assign on_last_face = (face_idx == last_face);

    // NOTE: all sequential state uses non-blocking assignments; later
    // assignments in this block intentionally override earlier ones
    // (e.g. lost is set for any busy-time face, then cleared at packet end).
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            tx_data   <= 8'h00;
            tx_send   <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            count     <= 7'd0;
            pkt_count <= 7'd0;
            lost      <= 1'b0;
            last_byte <= 1'b0;
            face_idx  <= '0;
            byte_idx  <= '0;
        end else begin
            // Any face arriving while a packet is in flight is dropped.
            if (state != IDLE && face_vld) begin
                lost <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (face_vld) begin
                        if (count < MAX_CNT) begin
                            count <= count + 7'd1;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                    // A face arriving with frame_done is already counted by
                    // the time the header is built in HDR_LOAD.
                    if (frame_done) begin
                        state <= HDR_LOAD;
                        busy  <= 1'b1;
                    end
                end

                HDR_LOAD: begin
                    tx_data   <= {overflow, count};
                    pkt_count <= count;
                    face_idx  <= '0;
                    byte_idx  <= '0;
                    last_byte <= (count == 7'd0);
                    tx_send   <= 1'b1;
                    state     <= SEND;
                end

                SEND: begin
                    if (tx_done) begin
                        tx_send <= 1'b0;
                        if (last_byte) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            count    <= 7'd0;
                            // A face dropped in this very cycle also counts.
                            overflow <= lost | face_vld;
                            lost     <= 1'b0;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end

                LOAD: begin
                    tx_data   <= cur_byte;
                    last_byte <= on_last_face && (byte_idx == LAST_BYTE);
                    if (byte_idx == LAST_BYTE) begin
                        byte_idx <= '0;
                        // Hold on the final face so the index never passes
                        // the latched count.
                        if (!on_last_face) begin
                            face_idx <= face_idx + 1'b1;
                        end
                    end else begin
                        byte_idx <= byte_idx + 1'b1;
                    end
                    tx_send <= 1'b1;
                    state   <= SEND;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/face_result_serializer.md
Name: face_result_serializer

Overview:
- Parametrised successor to the face-box queue and result-to-UART sender.
- Buffers up to MAX_FACES detected bounding boxes per frame. On end-of-frame it streams them to the UART transmitter as a counted byte packet with an overflow flag.
- Sits between the detect_face HLS wrapper outputs and uart_tcvr. Coordinate width is configurable.

Parameters:
- MAX_FACES, 30: buffer depth in faces; legal range 1..127.
- COORD_W, 8: coordinate width; legal values 8 or 16. BPC = COORD_W/8 bytes per coordinate.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- face_vld  in  1  one-cycle pulse; face coords valid this cycle
- face_x1  in  COORD_W  box left
- face_y1  in  COORD_W  box top
- face_x2  in  COORD_W  box right
- face_y2  in  COORD_W  box bottom
- frame_done  in  1  one-cycle pulse; detector finished current frame
- tx_data  out  8  byte to transmitter
- tx_send  out  1  level request to transmitter; held until tx_done
- tx_done  in  1  one-cycle pulse from transmitter; byte sent
- busy  out  1  high while a packet is being streamed
- overflow  out  1  sticky; faces lost for the current frame

Behaviour:
- Clocking and reset: single clock. Reset is synchronous and active-high.
- Reset values: tx_data=0, tx_send=0, busy=0, overflow=0, count=0, state=IDLE.
- Reset mid-packet: the next cycle has tx_send=0 and busy=0, the buffer is empty, and the remaining bytes are never sent.
- Storage: MAX_FACES x 4*COORD_W register array, written in arrival order. count is a 7-bit occupancy.
- Capture in IDLE, face_vld=1:
  - count<MAX_FACES: store the box at index count; count+1.
  - count==MAX_FACES: drop the box; overflow<=1.
- face_vld while busy: box dropped; lost<=1. lost is copied into overflow on the return to IDLE.
- frame_done while busy is ignored.
- face_vld and frame_done in the same IDLE cycle: the face is stored first and is included in this packet.
- Packet format:
  - Header byte = {overflow, count[6:0]}.
  - Then, for faces 0..count-1: x1, y1, x2, y2, each BPC bytes, MSB first.
  - count==0 gives a header-only packet (0x00, or 0x80 if overflow).
  - Total bytes = 1 + count*4*BPC.
- FSM:
  - IDLE: busy=0, tx_send=0. frame_done -> HDR_LOAD.
  - HDR_LOAD: tx_data<=header, latch packet count. -> SEND.
  - SEND: tx_send=1, tx_data stable. On tx_done:
    - more bytes remaining -> LOAD;
    - otherwise -> IDLE, with count<=0, overflow<=lost, lost<=0.
  - LOAD: tx_send=0; tx_data<=buffer byte (face_idx, byte_idx); advance byte_idx, which wraps at 4*BPC-1 and increments face_idx. -> SEND.
- busy=1 in every state except IDLE.
- tx_send is low for exactly one cycle between consecutive bytes.
- tx_data changes only in HDR_LOAD/LOAD.
- tx_done is ignored outside SEND.
- Latency: frame_done at cycle t -> tx_send high at t+2.
- Indices: face_idx and byte_idx use minimal widths and never exceed the latched count.

Test Plan:
- COORD_W=8; frame_done with no faces -> one byte 0x00, then busy=0 and tx_send=0.
- COORD_W=8; face (10,20,110,120) then frame_done -> bytes 0x01,0x0A,0x14,0x6E,0x78 in order; tx_send drops 1 cycle between bytes; tx_done delayed 1 and 50 cycles.
- COORD_W=16; face (0x0123,0x0045,0x0200,0x01FF) -> 0x01,0x01,0x23,0x00,0x45,0x02,0x00,0x01,0xFF.
- MAX_FACES=2, COORD_W=8; three faces A,B,C -> header 0x82, then the 8 bytes of A,B only; next empty frame header is 0x00.
- face_vld and frame_done in the same cycle -> that face is included (header 0x01). face_vld during busy -> dropped; next frame_done gives header 0x80.
- reset asserted while in SEND mid-packet -> tx_send=0 and busy=0 next cycle; a subsequent frame_done emits 0x00.
